scroll_reg_writer: RTL and testbench

CPU-side write front end for the M67673 raster scroller bank. Captures Z80 scroll-register writes on the rising edge of /CS|/WR into four 8-bit shadow registers. It then delivers each value to its scroller as a single-register commit: an active-low per-scroller enable plus shared data bus, aligned to the 6 MHz pixel clock enable. Commits are immediate, or deferred to vertical blank so mid-frame writes cannot tear the raster.

---
 rtl/scroll_reg_writer_pkg.sv | 25 ++
 rtl/scroll_reg_writer_if.sv | 23 ++
 rtl/scroll_reg_writer_cpu_wr_edge.sv | 51 +++++
 rtl/scroll_reg_writer.sv | 116 +++++++++++
 tb/tb_scroll_reg_writer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/scroll_reg_writer_pkg.sv
// Shared types and constants for the scroll register writer.
package scroll_pkg;

    localparam int unsigned NUM_SCROLL = 4;
    localparam int unsigned IDX_W      = 2;
    localparam int unsigned DATA_W     = 8;

    localparam logic [NUM_SCROLL-1:0] REGEN_IDLE = 4'hF;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } state_e;

    // Index of the lowest set bit; zero when nothing is set.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_SCROLL-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = NUM_SCROLL - 1; i >= 0; i--) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/scroll_reg_writer_if.sv
// CPU write bus in, scroller commit bus out.
interface scroll_reg_writer_if;
    import scroll_pkg::*;

    logic                  i_CS_n;
    logic                  i_WR_n;
    logic [IDX_W-1:0]      i_ADDR;
    logic [DATA_W-1:0]     i_DIN;
    logic [NUM_SCROLL-1:0] o_REGEN_n;
    logic [DATA_W-1:0]     o_REGDIN;
    logic                  o_BUSY;

    modport master (
        output i_CS_n, i_WR_n, i_ADDR, i_DIN,
        input  o_REGEN_n, o_REGDIN, o_BUSY
    );

    modport slave (
        input  i_CS_n, i_WR_n, i_ADDR, i_DIN,
        output o_REGEN_n, o_REGDIN, o_BUSY
    );

endinterface

// File: rtl/scroll_reg_writer_cpu_wr_edge.sv
// Z80 write strobe edge detector: one-cycle pulse on the rising edge of
// /CS|/WR, with address and data captured on that same cycle.
module cpu_wr_edge
    import scroll_pkg::*;
#(
    parameter int unsigned ADDR_W = IDX_W,
    parameter int unsigned DAT_W  = DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              cs_n_i,
    input  logic              wr_n_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DAT_W-1:0]  din_i,
    output logic              ev_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DAT_W-1:0]  din_o
);

    logic              s_q;
    logic              ev_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DAT_W-1:0]  din_q;
    logic              s_c;
    logic              rise_c;

    assign s_c    = cs_n_i | wr_n_i;
    assign rise_c = s_c & ~s_q;

    // Strobe history starts high so reset never produces a false event.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            s_q    <= 1'b1;
            ev_q   <= 1'b0;
            addr_q <= '0;
            din_q  <= '0;
        end else begin
            s_q  <= s_c;
            ev_q <= rise_c;
            if (rise_c) begin
                addr_q <= addr_i;
                din_q  <= din_i;
            end
        end
    end

    assign ev_o   = ev_q;
    assign addr_o = addr_q;
    assign din_o  = din_q;

endmodule

// File: rtl/scroll_reg_writer.sv
// Shadow registers plus commit FSM that delivers one scroller register per
// pixel-enable period, optionally deferred to vertical blank.
module scroll_reg_writer
    import scroll_pkg::*;
#(
    parameter logic [DATA_W-1:0] SHADOW_INIT = 8'd0
) (
    input  logic i_EMU_MCLK,
    input  logic i_EMU_RST_n,
    input  logic i_EMU_CLK6MPCEN_n,
    input  logic i_VBLANK,
    input  logic i_LATCHMODE,
    scroll_reg_writer_if.slave bus
);

    logic              wr_ev;
    logic [IDX_W-1:0]  wr_addr;
    logic [DATA_W-1:0] wr_din;

    logic [DATA_W-1:0]     shadow_q [NUM_SCROLL];
    logic [NUM_SCROLL-1:0] pending_q, pending_d;
    logic                  dirty_q, dirty_d;
    state_e                state_q, state_d;
    logic [IDX_W-1:0]      cur_q, cur_d;
    logic [NUM_SCROLL-1:0] regen_q, regen_d;
    logic [DATA_W-1:0]     regdin_q, regdin_d;
    logic                  busy_q, busy_d;
    logic [IDX_W-1:0]      pick_c;
    logic                  eligible_c;

    cpu_wr_edge #(
        .ADDR_W (IDX_W),
        .DAT_W  (DATA_W)
    ) u_wr_edge (
        .clk_i   (i_EMU_MCLK),
        .rst_n_i (i_EMU_RST_n),
        .cs_n_i  (bus.i_CS_n),
        .wr_n_i  (bus.i_WR_n),
        .addr_i  (bus.i_ADDR),
        .din_i   (bus.i_DIN),
        .ev_o    (wr_ev),
        .addr_o  (wr_addr),
        .din_o   (wr_din)
    );

    assign pick_c     = lowest_set(pending_q);
    assign eligible_c = !i_LATCHMODE || i_VBLANK;

    // Shadow registers take every CPU write immediately.
    always_ff @(posedge i_EMU_MCLK) begin
        if (!i_EMU_RST_n) begin
            for (int i = 0; i < NUM_SCROLL; i++) shadow_q[i] <= SHADOW_INIT;
        end else if (wr_ev) begin
            shadow_q[wr_addr] <= wr_din;
        end
    end

    // Next-state: priority pick in IDLE, hold until the pixel enable in DRIVE.
    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        dirty_d   = dirty_q;
        pending_d = pending_q;
        regen_d   = regen_q;
        regdin_d  = regdin_q;
        case (state_q)
            ST_IDLE: begin
                if (eligible_c && (pending_q != '0)) begin
                    cur_d    = pick_c;
                    regdin_d = shadow_q[pick_c];
                    regen_d  = ~(NUM_SCROLL'(1) << pick_c);
                    // A write landing on the pick edge already missed the latch.
                    dirty_d  = wr_ev && (wr_addr == pick_c);
                    state_d  = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (wr_ev && (wr_addr == cur_q)) dirty_d = 1'b1;
                if (!i_EMU_CLK6MPCEN_n) begin
                    regen_d = REGEN_IDLE;
                    state_d = ST_IDLE;
                    if (!dirty_q) pending_d[cur_q] = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (wr_ev) pending_d[wr_addr] = 1'b1;
        busy_d = (pending_d != '0) || (state_d == ST_DRIVE);
    end

    // State and output registers.
    always_ff @(posedge i_EMU_MCLK) begin
        if (!i_EMU_RST_n) begin
            state_q   <= ST_IDLE;
            cur_q     <= '0;
            dirty_q   <= 1'b0;
            pending_q <= '0;
            regen_q   <= REGEN_IDLE;
            regdin_q  <= SHADOW_INIT;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            dirty_q   <= dirty_d;
            pending_q <= pending_d;
            regen_q   <= regen_d;
            regdin_q  <= regdin_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.o_REGEN_n = regen_q;
    assign bus.o_REGDIN  = regdin_q;
    assign bus.o_BUSY    = busy_q;

endmodule

// File: tb/tb_scroll_reg_writer.sv
// Scoreboard bench for scroll_reg_writer: stimulus pushes expected commits,
// a negedge monitor pops them whenever a scroller would sample a write.
`timescale 1ns/1ps
module tb_scroll_reg_writer;

    typedef struct {
        logic [1:0] idx;
        logic [7:0] data;
    } exp_t;

    logic clk;
    logic rst_n;
    logic clk6_n;
    logic vblank;
    logic latchmode;
    int   en_cnt;
    int   tests;
    int   fails;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [3:0] mon_en;
    logic [7:0] m_data [4];
    bit         m_have [4];

    scroll_reg_writer_if bus ();

    scroll_reg_writer #(.SHADOW_INIT(8'h5A)) dut (
        .i_EMU_MCLK        (clk),
        .i_EMU_RST_n       (rst_n),
        .i_EMU_CLK6MPCEN_n (clk6_n),
        .i_VBLANK          (vblank),
        .i_LATCHMODE       (latchmode),
        .bus               (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pixel enable: low for one MCLK out of every eight.
    initial begin
        clk6_n = 1'b1;
        en_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            en_cnt = en_cnt + 1;
            clk6_n = (en_cnt % 8 == 0) ? 1'b0 : 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Strobe low for one cycle, rise; address/data held through the event cycle.
    task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
        bus.i_CS_n = 1'b0;
        bus.i_WR_n = 1'b0;
        bus.i_ADDR = a;
        bus.i_DIN  = d;
        tick();
        bus.i_CS_n = 1'b1;
        bus.i_WR_n = 1'b1;
        tick();
        bus.i_ADDR = 2'($urandom);
        bus.i_DIN  = 8'($urandom);
    endtask

    task automatic wait_idle(input int maxc, input string name);
        for (int i = 0; i < maxc && bus.o_BUSY; i++) tick();
        chk(name, 32'(bus.o_BUSY), 32'd0);
    endtask

    task automatic wait_drive(input int maxc, input string name);
        for (int i = 0; i < maxc && bus.o_REGEN_n == 4'hF; i++) tick();
        chk(name, 32'(bus.o_REGEN_n != 4'hF), 32'd1);
    endtask

    task automatic wait_en();
        for (int i = 0; i < 20; i++) begin
            tick();
            if (clk6_n == 1'b0) break;
        end
    endtask

    // A commit is whatever the scroller samples: enable low on a pixel-enable cycle.
    always @(negedge clk) begin
        if (rst_n && clk6_n == 1'b0 && bus.o_REGEN_n != 4'hF) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_commit: got regen %b data %h, expected no commit",
                         bus.o_REGEN_n, bus.o_REGDIN);
            end else begin
                mon_e  = exp_q.pop_front();
                mon_en = ~(4'b0001 << mon_e.idx);
                chk("commit_en", 32'(bus.o_REGEN_n), 32'(mon_en));
                chk("commit_data", 32'(bus.o_REGDIN), 32'(mon_e.data));
            end
        end
    end

    initial begin
        tests      = 0;
        fails      = 0;
        rst_n      = 1'b0;
        vblank     = 1'b0;
        latchmode  = 1'b0;
        bus.i_CS_n = 1'b1;
        bus.i_WR_n = 1'b1;
        bus.i_ADDR = 2'd0;
        bus.i_DIN  = 8'd0;
        repeat (3) tick();
        chk("reset_regen", 32'(bus.o_REGEN_n), 32'hF);
        chk("reset_regdin", 32'(bus.o_REGDIN), 32'h5A);
        chk("reset_busy", 32'(bus.o_BUSY), 32'd0);
        rst_n = 1'b1;
        repeat (20) tick();
        chk("quiet_regen", 32'(bus.o_REGEN_n), 32'hF);
        chk("quiet_busy", 32'(bus.o_BUSY), 32'd0);

        // Immediate commit latency and data.
        exp_q.push_back('{2'd2, 8'h3C});
        cpu_write(2'd2, 8'h3C);
        tick();
        chk("e1_regen", 32'(bus.o_REGEN_n), 32'hF);
        chk("e1_busy", 32'(bus.o_BUSY), 32'd1);
        tick();
        chk("e2_regen", 32'(bus.o_REGEN_n), 32'hB);
        chk("e2_regdin", 32'(bus.o_REGDIN), 32'h3C);
        wait_idle(30, "imm_idle");
        chk("imm_regen_off", 32'(bus.o_REGEN_n), 32'hF);

        // Several pending registers commit in index order.
        latchmode = 1'b1;
        cpu_write(2'd3, 8'hA3);
        cpu_write(2'd0, 8'hA0);
        cpu_write(2'd1, 8'hA1);
        exp_q.push_back('{2'd0, 8'hA0});
        exp_q.push_back('{2'd1, 8'hA1});
        exp_q.push_back('{2'd3, 8'hA3});
        latchmode = 1'b0;
        wait_idle(100, "order_idle");
        chk("order_drained", 32'(exp_q.size()), 32'd0);

        // Deferred to vblank; vblank falling mid-drive still completes.
        latchmode = 1'b1;
        cpu_write(2'd1, 8'h77);
        exp_q.push_back('{2'd1, 8'h77});
        repeat (30) tick();
        chk("hold_regen", 32'(bus.o_REGEN_n), 32'hF);
        chk("hold_busy", 32'(bus.o_BUSY), 32'd1);
        vblank = 1'b1;
        wait_drive(5, "vbl_drive");
        vblank = 1'b0;
        wait_idle(30, "vbl_idle");
        chk("vbl_drained", 32'(exp_q.size()), 32'd0);
        latchmode = 1'b0;

        // Rewrite during drive: old value commits, new value in a second pass.
        wait_en();
        exp_q.push_back('{2'd0, 8'h11});
        exp_q.push_back('{2'd0, 8'h22});
        cpu_write(2'd0, 8'h11);
        wait_drive(5, "rw_drive");
        chk("rw_regdin", 32'(bus.o_REGDIN), 32'h11);
        cpu_write(2'd0, 8'h22);
        tick();
        chk("rw_hold", 32'(bus.o_REGDIN), 32'h11);
        wait_idle(60, "rw_idle");
        chk("rw_drained", 32'(exp_q.size()), 32'd0);

        // Random batches gathered while held, released by vblank or mode.
        for (int b = 0; b < 20; b++) begin
            latchmode = 1'b1;
            vblank    = 1'b0;
            for (int i = 0; i < 4; i++) m_have[i] = 1'b0;
            for (int i = 0; i < int'($urandom_range(1, 6)); i++) begin
                logic [1:0] a;
                logic [7:0] d;
                a = 2'($urandom_range(0, 3));
                d = 8'($urandom);
                cpu_write(a, d);
                m_data[a] = d;
                m_have[a] = 1'b1;
            end
            tick();
            chk("rand_busy", 32'(bus.o_BUSY), 32'd1);
            for (int i = 0; i < 4; i++)
                if (m_have[i]) exp_q.push_back('{2'(i), m_data[i]});
            if ($urandom_range(0, 1) == 0) vblank = 1'b1;
            else latchmode = 1'b0;
            wait_idle(100, "rand_idle");
            chk("rand_drained", 32'(exp_q.size()), 32'd0);
            vblank = 1'b0;
        end

        // Reset mid-drive discards everything pending.
        latchmode = 1'b1;
        vblank    = 1'b0;
        cpu_write(2'd0, 8'hC0);
        cpu_write(2'd3, 8'hC3);
        wait_en();
        vblank = 1'b1;
        tick();
        chk("rst_pre_regen", 32'(bus.o_REGEN_n), 32'hE);
        rst_n = 1'b0;
        tick();
        chk("rst_regen", 32'(bus.o_REGEN_n), 32'hF);
        chk("rst_regdin", 32'(bus.o_REGDIN), 32'h5A);
        chk("rst_busy", 32'(bus.o_BUSY), 32'd0);
        rst_n     = 1'b1;
        latchmode = 1'b0;
        repeat (40) tick();
        chk("post_rst_busy", 32'(bus.o_BUSY), 32'd0);
        chk("final_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
